// File: rtl/ddr4_cmd_sequencer.sv
// Single-requester DDR4 command sequencer: ACT -> tRCD -> RD/WR -> tCL -> burst -> PRE -> tRP.
// Optional OPEN_PAGE_EN keeps the row open after a burst and skips ACT on a row hit.
module ddr4_cmd_sequencer #(
  parameter int unsigned RANKS     = 1,
  parameter int unsigned BGWIDTH   = 2,
  parameter int unsigned BAWIDTH   = 2,
  parameter int unsigned ADDRWIDTH = 17,
  parameter int unsigned COLWIDTH  = 10,
  parameter int unsigned BL        = 8,
  parameter int unsigned TRCD      = 15,
  parameter int unsigned TCL       = 15,
  parameter int unsigned TRP       = 15
) (
  input  logic                  ck_t,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [COLWIDTH-1:0]   req_col,
  output logic [RANKS-1:0]      cs_n,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BGWIDTH-1:0]    bg,
  output logic [BAWIDTH-1:0]    ba,
  output logic                  beat,
  output logic                  beat_wr,
  output logic [$clog2(BL)-1:0] beat_idx,
  output logic                  busy
);

  localparam int unsigned MaxA   = (TRCD > TCL) ? TRCD : TCL;
  localparam int unsigned MaxB   = (TRP > BL) ? TRP : BL;
  localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = $clog2(BL);

  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdRd  = 3'b101;
  localparam logic [2:0] CmdPre = 3'b010;

  typedef enum logic [2:0] {
    StIdle, StAct, StTrcdW, StCas, StClW, StBurst, StPre, StTrpW
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   wr_q, wr_d;
  logic [BGWIDTH-1:0]     rbg_q, rbg_d, bg_d;
  logic [BAWIDTH-1:0]     rba_q, rba_d, ba_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d, a_d;
  logic [COLWIDTH-1:0]    col_q, col_d;
  logic [IdxW-1:0]        idx_d;
`ifdef OPEN_PAGE_EN
  logic                   open_vld_q, open_vld_d;
  logic [BGWIDTH-1:0]     open_bg_q, open_bg_d;
  logic [BAWIDTH-1:0]     open_ba_q, open_ba_d;
  logic [ADDRWIDTH-1:0]   open_row_q, open_row_d;
`endif

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    rbg_d   = rbg_q;
    rba_d   = rba_q;
    row_d   = row_q;
    col_d   = col_q;
`ifdef OPEN_PAGE_EN
    open_vld_d = open_vld_q;
    open_bg_d  = open_bg_q;
    open_ba_d  = open_ba_q;
    open_row_d = open_row_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          wr_d  = req_write;
          rbg_d = req_bg;
          rba_d = req_ba;
          row_d = req_row;
          col_d = req_col;
`ifdef OPEN_PAGE_EN
          if (!open_vld_q) begin
            state_d = StAct;
          end else if (req_bg == open_bg_q && req_ba == open_ba_q && req_row == open_row_q) begin
            state_d = StCas;
          end else begin
            // Close the open bank first; pend_q routes tRP into the ACT of the new row.
            state_d = StPre;
            pend_d  = 1'b1;
          end
`else
          state_d = StAct;
`endif
        end
      end
      StAct: begin
        pend_d = 1'b0;
        if (TRCD == 1) begin
          state_d = StCas;
        end else begin
          state_d = StTrcdW;
          cnt_d   = CntW'(TRCD - 1);
        end
      end
      StTrcdW: begin
        if (cnt_q == CntW'(1)) state_d = StCas;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StCas: begin
        if (TCL == 1) begin
          state_d = StBurst;
          cnt_d   = CntW'(BL);
        end else begin
          state_d = StClW;
          cnt_d   = CntW'(TCL - 1);
        end
      end
      StClW: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StBurst;
          cnt_d   = CntW'(BL);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBurst: begin
        if (cnt_q == CntW'(1)) begin
`ifdef OPEN_PAGE_EN
          state_d    = StIdle;
          open_vld_d = 1'b1;
          open_bg_d  = rbg_q;
          open_ba_d  = rba_q;
          open_row_d = row_q;
`else
          state_d = StPre;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPre: begin
        if (TRP == 1) begin
          state_d = pend_q ? StAct : StIdle;
        end else begin
          state_d = StTrpW;
          cnt_d   = CntW'(TRP - 1);
        end
      end
      StTrpW: begin
        if (cnt_q == CntW'(1)) state_d = pend_q ? StAct : StIdle;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q after the edge.
  always_comb begin : out_decode
    a_d  = '0;
    bg_d = rbg_d;
    ba_d = rba_d;
    unique case (state_d)
      StAct: a_d = row_d;
      StCas: begin
        a_d[ADDRWIDTH-1 -: 3] = wr_d ? CmdWr : CmdRd;
        a_d[COLWIDTH-1:0]     = col_d;
      end
      StPre: begin
        a_d[ADDRWIDTH-1 -: 3] = CmdPre;
`ifdef OPEN_PAGE_EN
        if (pend_d) begin
          bg_d = open_bg_q;
          ba_d = open_ba_q;
        end
`endif
      end
      default: ;
    endcase
    idx_d = (state_d == StBurst && state_q == StBurst) ? beat_idx + IdxW'(1) : '0;
  end

  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      wr_q      <= 1'b0;
      rbg_q     <= '0;
      rba_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cs_n      <= '1;
      act_n     <= 1'b1;
      A         <= '0;
      bg        <= '0;
      ba        <= '0;
      req_ready <= 1'b0;
      beat      <= 1'b0;
      beat_wr   <= 1'b0;
      beat_idx  <= '0;
      busy      <= 1'b0;
`ifdef OPEN_PAGE_EN
      open_vld_q <= 1'b0;
      open_bg_q  <= '0;
      open_ba_q  <= '0;
      open_row_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      wr_q      <= wr_d;
      rbg_q     <= rbg_d;
      rba_q     <= rba_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cs_n      <= '0;
      act_n     <= (state_d != StAct);
      A         <= a_d;
      bg        <= bg_d;
      ba        <= ba_d;
      req_ready <= (state_d == StIdle);
      beat      <= (state_d == StBurst);
      beat_wr   <= (state_d == StBurst) && wr_d;
      beat_idx  <= idx_d;
      busy      <= (state_d != StIdle);
`ifdef OPEN_PAGE_EN
      open_vld_q <= open_vld_d;
      open_bg_q  <= open_bg_d;
      open_ba_q  <= open_ba_d;
      open_row_q <= open_row_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed, table-driven bench for ddr4_cmd_sequencer at default parameters.
// Cycle c of a transaction is the c-th clock period after the accepting edge, sampled at its negedge.
module tb_ddr4_cmd_sequencer;

  localparam int NOBS = 60;

  logic        ck_t      = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_bg    = '0;
  logic [1:0]  req_ba    = '0;
  logic [16:0] req_row   = '0;
  logic [9:0]  req_col   = '0;
  logic        req_ready;
  logic [0:0]  cs_n;
  logic        act_n;
  logic [16:0] A;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic        beat;
  logic        beat_wr;
  logic [2:0]  beat_idx;
  logic        busy;

  always #5 ck_t = ~ck_t;

  ddr4_cmd_sequencer dut (
    .ck_t(ck_t), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .beat(beat), .beat_wr(beat_wr), .beat_idx(beat_idx), .busy(busy)
  );

  // {act_n, A, bg, ba, beat, beat_wr, beat_idx, req_ready, busy}
  typedef logic [28:0] snap_t;
  typedef struct { logic wr; logic [1:0] bg; logic [1:0] ba; logic [16:0] row; logic [9:0] col; } req_t;
  typedef struct { int txn; int cyc; snap_t exp; } vec_t;

  localparam snap_t RstSnap = {1'b1, 28'd0};

  int    checks = 0;
  int    fails  = 0;
  snap_t obs [1:NOBS];
  req_t  txns [3];
  vec_t  vecs [$];

  function automatic snap_t now_snap();
    return {act_n, A, bg, ba, beat, beat_wr, beat_idx, req_ready, busy};
  endfunction

  function automatic snap_t mk(logic an, logic [16:0] a, logic [1:0] g, logic [1:0] b, logic bt,
                               logic bw, logic [2:0] ix, logic rd, logic bs);
    return {an, a, g, b, bt, bw, ix, rd, bs};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void add(int t, int c, snap_t e);
    vec_t v;
    v.txn = t;
    v.cyc = c;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  // Expected closed-page timeline with defaults: ACT@1, CAS@16, beats@31..38, PRE@39, ready@54.
  function automatic void fill_txn(int t);
    req_t        r = txns[t];
    logic [16:0] cas;
    int          nops [6] = '{2, 15, 17, 30, 40, 53};
    cas = (r.wr ? 17'h10000 : 17'h14000) | {7'd0, r.col};
    add(t, 1, mk(1'b0, r.row, r.bg, r.ba, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    foreach (nops[i]) add(t, nops[i], mk(1'b1, 17'd0, r.bg, r.ba, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    add(t, 16, mk(1'b1, cas, r.bg, r.ba, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++)
      add(t, 31 + i, mk(1'b1, 17'd0, r.bg, r.ba, 1'b1, r.wr, 3'(i), 1'b0, 1'b1));
    add(t, 39, mk(1'b1, 17'h08000, r.bg, r.ba, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    add(t, 54, mk(1'b1, 17'd0, r.bg, r.ba, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
  endfunction

  task automatic drive(input req_t r);
    req_write = r.wr;
    req_bg    = r.bg;
    req_ba    = r.ba;
    req_row   = r.row;
    req_col   = r.col;
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge ck_t);
    while (!req_ready && w < 200) begin
      @(negedge ck_t);
      w++;
    end
    check("ready_wait", 64'(req_ready), 64'(1));
  endtask

  task automatic issue(input req_t r);
    wait_ready();
    drive(r);
    req_valid = 1'b1;
    @(posedge ck_t);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= NOBS; c++) begin
      @(negedge ck_t);
      obs[c] = now_snap();
    end
  endtask

  task automatic compare_txn(input int t);
    foreach (vecs[i])
      if (vecs[i].txn == t)
        check($sformatf("txn%0d_cyc%0d", t, vecs[i].cyc), 64'(obs[vecs[i].cyc]), 64'(vecs[i].exp));
  endtask

  initial begin
    int          nact;
    int          act1;
    int          act2;
    logic [16:0] row2;

    txns[0] = '{wr: 1'b1, bg: 2'd1, ba: 2'd1, row: 17'd1, col: 10'd0};
    txns[1] = '{wr: 1'b0, bg: 2'd1, ba: 2'd1, row: 17'd1, col: 10'd0};
    txns[2] = '{wr: 1'b0, bg: 2'd2, ba: 2'd3, row: 17'h1ABCD, col: 10'h2A5};
    for (int t = 0; t < 3; t++) fill_txn(t);

    // Reset held 3 cycles, then release.
    repeat (3) @(posedge ck_t);
    @(negedge ck_t);
    check("reset_outputs", 64'(now_snap()), 64'(RstSnap));
    check("reset_cs_n", 64'(cs_n), 64'(1));
    reset = 1'b0;
    @(posedge ck_t);
    #1;
    check("post_reset_cs_n", 64'(cs_n), 64'(0));
    check("post_reset_ready", 64'(req_ready), 64'(1));

`ifdef OPEN_PAGE_EN
    issue(txns[0]);
    check("op_act", 64'(obs[1]), 64'(mk(1'b0, 17'd1, 2'd1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1)));
    check("op_wr", 64'(obs[16]), 64'(mk(1'b1, 17'h10000, 2'd1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1)));
    check("op_no_pre", 64'(obs[39]), 64'(mk(1'b1, 17'd0, 2'd1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0)));
    issue('{wr: 1'b0, bg: 2'd1, ba: 2'd1, row: 17'd1, col: 10'd5});
    check("op_hit_cas", 64'(obs[1]), 64'(mk(1'b1, 17'h14005, 2'd1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1)));
    check("op_hit_beat", 64'(obs[16]), 64'(mk(1'b1, 17'd0, 2'd1, 2'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1)));
    issue('{wr: 1'b1, bg: 2'd2, ba: 2'd0, row: 17'd7, col: 10'd0});
    check("op_miss_pre", 64'(obs[1]), 64'(mk(1'b1, 17'h08000, 2'd1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1)));
    check("op_miss_trp", 64'(obs[15][28]), 64'(1));
    check("op_miss_act", 64'(obs[16]), 64'(mk(1'b0, 17'd7, 2'd2, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1)));
`else
    // Table-driven transactions: write, read same address, read with row/column pattern.
    for (int t = 0; t < 3; t++) begin
      issue(txns[t]);
      compare_txn(t);
    end

    // req_valid held through busy with the next request queued behind it.
    nact = 0;
    act1 = 0;
    act2 = 0;
    row2 = '0;
    wait_ready();
    drive(txns[0]);
    req_valid = 1'b1;
    @(posedge ck_t);
    #1 drive(txns[2]);
    for (int c = 1; c <= 70; c++) begin
      @(negedge ck_t);
      if (!act_n) begin
        nact++;
        if (nact == 1) act1 = c;
        if (nact == 2) begin
          act2      = c;
          row2      = A;
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("held_act_count", 64'(nact), 64'(2));
    check("held_first_act", 64'(act1), 64'(1));
    check("held_second_act", 64'(act2), 64'(55));
    check("held_second_row", 64'(row2), 64'(17'h1ABCD));

    // Reset at the first beat: immediate revert, no PRE, then a fresh full sequence.
    wait_ready();
    drive(txns[0]);
    req_valid = 1'b1;
    @(posedge ck_t);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 31; c++) @(negedge ck_t);
    check("first_beat_seen", 64'(beat), 64'(1));
    reset = 1'b1;
    #1;
    check("midburst_reset", 64'(now_snap()), 64'(RstSnap));
    check("midburst_reset_cs_n", 64'(cs_n), 64'(1));
    for (int c = 0; c < 3; c++) begin
      @(negedge ck_t);
      check($sformatf("reset_hold_%0d", c), 64'(now_snap()), 64'(RstSnap));
    end
    reset = 1'b0;
    issue(txns[0]);
    compare_txn(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
